mc_comp: RTL and testbench
==========================

MC_COMP -- requirements
Module: mc_comp

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, giving the unified instruction/data memory depth in 32-bit words.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 reg_sel  input  5  debug register-file read index.
REQ-006 reg_data  output  32  debug read data, combinational = GPR[reg_sel]; 0 when reg_sel=0.

Function
REQ-007 The block SHALL be a multi-cycle MIPS-32 CPU sharing one memory for instructions and data.
- Memory word index = byte address[log2(MEM_WORDS)+1:2].
- Memory read is combinational.
- Memory write is synchronous.
REQ-008 The supported instructions SHALL be:
- R-type: addu, subu, and, or, slt, sll, srl.
- I-type: addi, addiu, andi, ori, lui, slti, lw, sw, beq, bne.
- J-type: j, jal.
- The register form jr.
- addi SHALL NOT trap on overflow.
REQ-009 The control FSM states SHALL be: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP.
REQ-010 FETCH SHALL latch IR=mem[PC] and write PC=PC+4.
REQ-011 DECODE SHALL latch A=GPR[rs] and B=GPR[rt], and precompute the branch target PC+4+(sext(imm)<<2) into ALUOut.
REQ-012 The per-instruction state sequences SHALL be:
- Cycle counts: lw 5 (..MEMADR, MEMRD, MEMWB), sw 4 (..MEMADR, MEMWR), R-type/ALU-immediate 4 (..EXEC, ALUWB), beq/bne 3 (..BRANCH), j/jal/jr 3 (..JUMP).
- Every sequence SHALL return to FETCH.
REQ-013 Immediate extension SHALL be:
- Zero-extend for andi and ori.
- lui produces imm<<16.
- Sign-extend otherwise.
REQ-014 slt/slti SHALL compare signed.
REQ-015 Shifts SHALL use the shamt field.
REQ-016 Write destination SHALL be:
- R-type writes rd.
- I-type writes rt.
- jal writes r31 with the PC+4 of the jal.
REQ-017 Jump target SHALL be {PC[31:28], addr26, 2'b00}; jr SHALL load PC=A.
REQ-018 Branch SHALL update PC only when the condition holds (beq: A==B, bne: A!=B).
REQ-019 Writes to r0 SHALL be discarded; r0 SHALL always read 0.
REQ-020 An unrecognised opcode or funct SHALL be treated as a NOP: DECODE then FETCH, with no register or memory write.
REQ-021 The register file SHALL have two combinational read ports for the datapath plus the reg_sel debug port, and one synchronous write port.

Reset
REQ-022 While rstn=0 the block SHALL asynchronously force:
- PC=RESET_PC and state=FETCH.
- IR, A, B, ALUOut and MDR to 0.
- All GPRs to 0.
REQ-023 Memory contents SHALL NOT be reset; the memory is preloaded before reset release.
REQ-024 Reset mid-instruction SHALL abort the instruction: no partial register or memory write after rstn falls.
REQ-025 The first fetch SHALL occur on the first rising clk after rstn rises.

Structure
REQ-026 Opcode, funct, ALU-op and FSM-state encodings SHALL be constants in a shared package mc_comp_pkg.
REQ-027 Memory SHALL be a sub-module instance named U_MEM with an internal array named dmem [0:MEM_WORDS-1] of 32-bit words, loadable hierarchically by $readmemh.
- The ALU, register file and FSM SHALL be inline in mc_comp.

Verification
REQ-028 Scenario "addi": reset, then program addi $7,$0,5 at address 0 -> after 4 cycles reg_sel=7 gives reg_data=5.
REQ-029 Scenario "lw/sw": addi $1,$0,0x40; addi $2,$0,-1; sw $2,0($1); lw $7,0($1) -> dmem[16]=32'hFFFFFFFF and GPR7=32'hFFFFFFFF.
REQ-030 Scenario "branch": beq $0,$0,+1 skips the next addi -> the skipped register stays 0; bne $0,$0 does not branch and takes 3 cycles.
REQ-031 Scenario "jal/jr": jal 0x10 then jr $31 -> GPR31=4 and PC returns to 4.
REQ-032 Scenario "r0": addi $0,$0,9 -> reg_sel=0 gives 0.
REQ-033 Scenario "reset mid-instruction": rstn low during MEMWR of sw -> memory unchanged and PC=0 on release.

Source files
------------

// File: rtl/mc_comp_pkg.sv
// Shared encodings for the multi-cycle MIPS-32 core: opcodes, functs, ALU ops and FSM states.
package mc_comp_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluSrl, AluLui
    } alu_op_e;

    // Instruction class chosen in DECODE; selects the state sequence.
    typedef enum logic [2:0] {
        ClsNop, ClsMem, ClsAlu, ClsBranch, ClsJump
    } instr_cls_e;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
        StMemWr, StExec, StAluWb, StBranch, StJump
    } state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_comp_mem.sv
// Unified instruction/data memory: combinational read, synchronous write, no reset.
module mc_comp_mem #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] dmem [0:MEM_WORDS-1];

    assign rdata = dmem[addr];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            dmem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/mc_comp.sv
// Multi-cycle MIPS-32 subset core with a shared instruction/data memory.
module mc_comp
    import mc_comp_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] gpr_q [0:31];

    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_rdata;

    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    // Instruction fields
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign funct = ir_q[5:0];
    assign imm   = ir_q[15:0];

    instr_cls_e  cls;
    alu_op_e     alu_op;
    logic        use_imm;
    logic [31:0] imm_ext;
    logic [31:0] src_b;
    logic [31:0] alu_res;
    logic [31:0] branch_target;
    logic        take_branch;

    // Decode instruction class, ALU operation and immediate extension
    always_comb begin
        cls     = ClsNop;
        alu_op  = AluAdd;
        use_imm = 1'b1;
        imm_ext = sext16(imm);
        case (op)
            OP_RTYPE: begin
                use_imm = 1'b0;
                case (funct)
                    FN_ADDU: begin cls = ClsAlu; alu_op = AluAdd; end
                    FN_SUBU: begin cls = ClsAlu; alu_op = AluSub; end
                    FN_AND:  begin cls = ClsAlu; alu_op = AluAnd; end
                    FN_OR:   begin cls = ClsAlu; alu_op = AluOr;  end
                    FN_SLT:  begin cls = ClsAlu; alu_op = AluSlt; end
                    FN_SLL:  begin cls = ClsAlu; alu_op = AluSll; end
                    FN_SRL:  begin cls = ClsAlu; alu_op = AluSrl; end
                    FN_JR:   cls = ClsJump;
                    default: cls = ClsNop;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin cls = ClsAlu; alu_op = AluAdd; end
            OP_SLTI:           begin cls = ClsAlu; alu_op = AluSlt; end
            OP_ANDI: begin
                cls     = ClsAlu;
                alu_op  = AluAnd;
                imm_ext = {16'h0000, imm};
            end
            OP_ORI: begin
                cls     = ClsAlu;
                alu_op  = AluOr;
                imm_ext = {16'h0000, imm};
            end
            OP_LUI: begin
                cls     = ClsAlu;
                alu_op  = AluLui;
                imm_ext = {16'h0000, imm};
            end
            OP_LW, OP_SW:      cls = ClsMem;
            OP_BEQ, OP_BNE:    cls = ClsBranch;
            OP_J, OP_JAL:      cls = ClsJump;
            default:           cls = ClsNop;
        endcase
    end

    // ALU on the latched operands; also forms lw/sw addresses in MEMADR
    always_comb begin
        src_b   = use_imm ? imm_ext : b_q;
        alu_res = '0;
        case (alu_op)
            AluAdd:  alu_res = a_q + src_b;
            AluSub:  alu_res = a_q - src_b;
            AluAnd:  alu_res = a_q & src_b;
            AluOr:   alu_res = a_q | src_b;
            AluSlt:  alu_res = {31'b0, $signed(a_q) < $signed(src_b)};
            AluSll:  alu_res = src_b << shamt;
            AluSrl:  alu_res = src_b >> shamt;
            AluLui:  alu_res = {src_b[15:0], 16'h0000};
            default: alu_res = '0;
        endcase
    end

    // pc_q already holds PC+4 when DECODE runs
    assign branch_target = pc_q + (sext16(imm) << 2);
    assign take_branch   = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

    assign mem_idx = (state_q == StFetch) ? pc_q[AW+1:2] : alu_out_q[AW+1:2];

    // Control FSM next state and datapath register updates
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        mem_we    = 1'b0;
        gpr_we    = 1'b0;
        gpr_waddr = rt;
        gpr_wdata = alu_out_q;
        case (state_q)
            StFetch: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 32'd4;
                state_d = StDecode;
            end
            StDecode: begin
                a_d       = gpr_q[rs];
                b_d       = gpr_q[rt];
                alu_out_d = branch_target;
                case (cls)
                    ClsMem:    state_d = StMemAdr;
                    ClsAlu:    state_d = StExec;
                    ClsBranch: state_d = StBranch;
                    ClsJump:   state_d = StJump;
                    default:   state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                alu_out_d = alu_res;
                state_d   = (op == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mdr_d   = mem_rdata;
                state_d = StMemWb;
            end
            StMemWb: begin
                gpr_we    = 1'b1;
                gpr_wdata = mdr_q;
                state_d   = StFetch;
            end
            StMemWr: begin
                mem_we  = 1'b1;
                state_d = StFetch;
            end
            StExec: begin
                alu_out_d = alu_res;
                state_d   = StAluWb;
            end
            StAluWb: begin
                gpr_we    = 1'b1;
                gpr_waddr = (op == OP_RTYPE) ? rd : rt;
                state_d   = StFetch;
            end
            StBranch: begin
                if (take_branch) begin
                    pc_d = alu_out_q;
                end
                state_d = StFetch;
            end
            StJump: begin
                if (op == OP_RTYPE) begin
                    pc_d = a_q;
                end else begin
                    pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                end
                if (op == OP_JAL) begin
                    gpr_we    = 1'b1;
                    gpr_waddr = 5'd31;
                    gpr_wdata = pc_q;
                end
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Control and datapath state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    // Register file write port; r0 writes are dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (gpr_we && (gpr_waddr != 5'd0)) begin
            gpr_q[gpr_waddr] <= gpr_wdata;
        end
    end

    assign reg_data = (reg_sel == 5'd0) ? 32'h0 : gpr_q[reg_sel];

    // Write enable gated by rstn so a reset never lands a partial store
    mc_comp_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) U_MEM (
        .clk   (clk),
        .we    (mem_we && rstn),
        .addr  (mem_idx),
        .wdata (b_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mc_comp.sv
// Directed bench for mc_comp: ALU vector table plus multi-cycle scenario sequences.
module tb_mc_comp;
    import mc_comp_pkg::*;

    logic        clk;
    logic        rstn;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [0:7];

    mc_comp #(
        .MEM_WORDS (1024),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:15];
    int   nvec;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        logic [4:0] r1, r2, r3, s;
        r1 = rs[4:0];
        r2 = rt[4:0];
        r3 = rd[4:0];
        s  = sh[4:0];
        return {OP_RTYPE, r1, r2, r3, s, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        logic [4:0] r1, r2;
        r1 = rs[4:0];
        r2 = rt[4:0];
        return {op, r1, r2, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 8; i++) prog[i] = 32'h0;
    endtask

    // Hold reset, reload memory with prog[], release at a falling edge
    task automatic start();
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 1024; i++) dut.U_MEM.dmem[i] = 32'h0;
        for (int i = 0; i < 8; i++) dut.U_MEM.dmem[i] = prog[i];
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reg(input string name, input int sel, input logic [31:0] exp);
        reg_sel = sel[4:0];
        #1;
        check(name, reg_data, exp);
    endtask

    initial begin
        rstn    = 1'b0;
        reg_sel = 5'd0;

        // $1 = -16, $2 = 0x35 precede each vector's instruction
        nvec = 0;
        vecs[nvec++] = '{"addu",  rtype(1, 2, 3, 0, FN_ADDU),          32'h0000_0025};
        vecs[nvec++] = '{"subu",  rtype(2, 1, 3, 0, FN_SUBU),          32'h0000_0045};
        vecs[nvec++] = '{"and",   rtype(1, 2, 3, 0, FN_AND),           32'h0000_0030};
        vecs[nvec++] = '{"or",    rtype(1, 2, 3, 0, FN_OR),            32'hFFFF_FFF5};
        vecs[nvec++] = '{"slt_t", rtype(1, 2, 3, 0, FN_SLT),           32'h0000_0001};
        vecs[nvec++] = '{"slt_f", rtype(2, 1, 3, 0, FN_SLT),           32'h0000_0000};
        vecs[nvec++] = '{"sll",   rtype(0, 2, 3, 4, FN_SLL),           32'h0000_0350};
        vecs[nvec++] = '{"srl",   rtype(0, 1, 3, 4, FN_SRL),           32'h0FFF_FFFF};
        vecs[nvec++] = '{"addi",  itype(OP_ADDI, 1, 3, 16'hFFFF),      32'hFFFF_FFEF};
        vecs[nvec++] = '{"addiu", itype(OP_ADDIU, 2, 3, 16'h8000),     32'hFFFF_8035};
        vecs[nvec++] = '{"andi",  itype(OP_ANDI, 1, 3, 16'hFF0F),      32'h0000_FF00};
        vecs[nvec++] = '{"ori",   itype(OP_ORI, 2, 3, 16'h8000),       32'h0000_8035};
        vecs[nvec++] = '{"lui",   itype(OP_LUI, 0, 3, 16'h1234),       32'h1234_0000};
        vecs[nvec++] = '{"slti_t", itype(OP_SLTI, 1, 3, 16'hFFF1),     32'h0000_0001};
        vecs[nvec++] = '{"slti_f", itype(OP_SLTI, 2, 3, 16'hFFFF),     32'h0000_0000};
        vecs[nvec++] = '{"bad_fn", rtype(1, 2, 3, 0, 6'h3F),           32'h0000_0000};

        // Reset state
        cycles(2);
        check("rst_pc", dut.pc_q, 32'h0);
        check("rst_state", {28'h0, dut.state_q}, {28'h0, StFetch});
        check("rst_ir", dut.ir_q, 32'h0);
        check_reg("rst_r0", 0, 32'h0);

        // ALU vector table
        for (int v = 0; v < nvec; v++) begin
            clear_prog();
            prog[0] = itype(OP_ADDI, 0, 1, 16'hFFF0);
            prog[1] = itype(OP_ADDI, 0, 2, 16'h0035);
            prog[2] = vecs[v].instr;
            start();
            cycles(12);
            check_reg(vecs[v].name, 3, vecs[v].exp);
        end

        // Unknown opcode is a 2-cycle NOP
        clear_prog();
        prog[0] = 32'hFC03_0001;
        prog[1] = itype(OP_ADDI, 0, 4, 16'h0006);
        start();
        cycles(2);
        check("nop_pc", dut.pc_q, 32'h4);
        check("nop_state", {28'h0, dut.state_q}, {28'h0, StFetch});
        cycles(4);
        check_reg("nop_r3", 3, 32'h0);
        check_reg("nop_next", 4, 32'h6);

        // GPRs cleared by reset
        start();
        check_reg("rst_gpr4", 4, 32'h0);

        // addi scenario
        clear_prog();
        prog[0] = itype(OP_ADDI, 0, 7, 16'h0005);
        start();
        cycles(4);
        check_reg("addi_r7", 7, 32'h5);
        check("addi_pc", dut.pc_q, 32'h4);

        // lw/sw scenario
        clear_prog();
        prog[0] = itype(OP_ADDI, 0, 1, 16'h0040);
        prog[1] = itype(OP_ADDI, 0, 2, 16'hFFFF);
        prog[2] = itype(OP_SW, 1, 2, 16'h0000);
        prog[3] = itype(OP_LW, 1, 7, 16'h0000);
        start();
        cycles(12);
        check("sw_mem", dut.U_MEM.dmem[16], 32'hFFFF_FFFF);
        cycles(4);
        check_reg("lw_lat", 7, 32'h0);
        cycles(1);
        check_reg("lw_r7", 7, 32'hFFFF_FFFF);

        // branch scenario
        clear_prog();
        prog[0] = itype(OP_BEQ, 0, 0, 16'h0001);
        prog[1] = itype(OP_ADDI, 0, 5, 16'h0007);
        prog[2] = itype(OP_ADDI, 0, 6, 16'h0003);
        prog[3] = itype(OP_BNE, 0, 0, 16'h0001);
        prog[4] = itype(OP_ADDI, 0, 8, 16'h0002);
        start();
        cycles(3);
        check("beq_pc", dut.pc_q, 32'h8);
        cycles(6);
        check("bne_state", {28'h0, dut.state_q}, {28'h0, StBranch});
        cycles(1);
        check("bne_pc", dut.pc_q, 32'h10);
        check("bne_done", {28'h0, dut.state_q}, {28'h0, StFetch});
        cycles(4);
        check_reg("br_skip", 5, 32'h0);
        check_reg("br_r6", 6, 32'h3);
        check_reg("br_r8", 8, 32'h2);

        // jal/jr scenario
        clear_prog();
        prog[0] = {OP_JAL, 26'h000_0004};
        prog[1] = itype(OP_ADDI, 0, 9, 16'h0001);
        prog[4] = rtype(31, 0, 0, 0, FN_JR);
        start();
        cycles(3);
        check("jal_pc", dut.pc_q, 32'h10);
        check_reg("jal_r31", 31, 32'h4);
        cycles(3);
        check("jr_pc", dut.pc_q, 32'h4);
        cycles(4);
        check_reg("jr_r9", 9, 32'h1);

        // r0 scenario
        clear_prog();
        prog[0] = itype(OP_ADDI, 0, 0, 16'h0009);
        start();
        cycles(4);
        check_reg("r0_sel", 0, 32'h0);
        check("r0_gpr", dut.gpr_q[0], 32'h0);

        // Reset during MEMWR of sw
        clear_prog();
        prog[0] = itype(OP_ADDI, 0, 1, 16'h0040);
        prog[1] = itype(OP_ADDI, 0, 2, 16'hFFFF);
        prog[2] = itype(OP_SW, 1, 2, 16'h0000);
        start();
        dut.U_MEM.dmem[16] = 32'h1234_5678;
        cycles(11);
        check("mw_state", {28'h0, dut.state_q}, {28'h0, StMemWr});
        rstn = 1'b0;
        #1;
        check("mw_rst_pc", dut.pc_q, 32'h0);
        cycles(2);
        check("mw_mem", dut.U_MEM.dmem[16], 32'h1234_5678);
        check_reg("mw_r1", 1, 32'h0);
        rstn = 1'b1;
        check("mw_rel_pc", dut.pc_q, 32'h0);
        cycles(1);
        check("mw_first_fetch", dut.pc_q, 32'h4);
        check("mw_ir", dut.ir_q, itype(OP_ADDI, 0, 1, 16'h0040));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
